pcm_stereo_buffer: RTL

//  Output stage after the subband synthesis filter. Captures the 16-bit PCM sample

---
 rtl/pcm_stereo_buffer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pcm_stereo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pcm_stereo_buffer
// Description : PCM output stage behind the subband synthesis filter. Samples
//               are collected per channel into a granule ring buffer (two
//               RAMs, L and R) and handed to the codec serializer as
//               interleaved stereo pairs over a valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module pcm_stereo_buffer #(
  parameter int LOG2_BLOCKS  = 2,
  parameter int PRIME_BLOCKS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Flush_I,
  input  logic        Stereo_I,
  input  logic [15:0] Sample_Data_I,
  input  logic        Sample_Write_En_I,
  input  logic        Channel_I,
  output logic        Block_Free_O,
  output logic        Pair_Valid_O,
  input  logic        Pair_Ready_I,
  output logic [15:0] Left_Data_O,
  output logic [15:0] Right_Data_O,
  output logic        Overflow_O,
  output logic        Underflow_O,
  input  logic        Clear_Flags_I
);

  localparam int BLOCKS = 1 << LOG2_BLOCKS;
  localparam int DEPTH  = BLOCKS * 32;
  localparam int AW     = LOG2_BLOCKS + 5;
  localparam int CW     = LOG2_BLOCKS + 1;
  localparam logic [CW-1:0] C_BLOCKS   = CW'(BLOCKS);
  localparam logic [CW-1:0] C_PRIME    = CW'(PRIME_BLOCKS);
  localparam logic [4:0]    C_LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [LOG2_BLOCKS-1:0]   wg_q, wg_d;
  logic [4:0]               wsl_q, wsl_d;
  logic [4:0]               wsr_q, wsr_d;
  logic [LOG2_BLOCKS-1:0]   rg_q, rg_d;
  logic [4:0]               rs_q, rs_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     primed_q, primed_d;
  logic                     valid_q, valid_d;
  logic [15:0]              left_q, left_d;
  logic [15:0]              right_q, right_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic [15:0]              ram_l_q [DEPTH];
  logic [15:0]              ram_r_q [DEPTH];
  logic [15:0]              rd_l_q;
  logic [15:0]              rd_r_q;

  logic                     w_full;
  logic                     w_wr_l;
  logic                     w_wr_r;
  logic [AW-1:0]            w_addr_l;
  logic [AW-1:0]            w_addr_r;
  logic [AW-1:0]            w_rd_addr;
  logic                     w_commit;
  logic                     w_release;
  logic                     w_ovf_set;
  logic                     w_unf_set;

  assign w_full       = (count_q == C_BLOCKS);
  assign w_rd_addr    = {rg_q, rs_q};
  assign Block_Free_O = (count_q < C_BLOCKS);
  assign Pair_Valid_O = valid_q;
  assign Left_Data_O  = left_q;
  assign Right_Data_O = right_q;
  assign Overflow_O   = ovf_q;
  assign Underflow_O  = unf_q;

  // Write side: route a sample to its channel RAM(s), advance indices, detect granule commit.
  always_comb begin
    wg_d      = wg_q;
    wsl_d     = wsl_q;
    wsr_d     = wsr_q;
    w_wr_l    = 1'b0;
    w_wr_r    = 1'b0;
    w_addr_l  = {wg_q, wsl_q};
    w_addr_r  = {wg_q, wsr_q};
    w_commit  = 1'b0;
    w_ovf_set = 1'b0;
    if (Sample_Write_En_I && !Flush_I) begin
      if (w_full) begin
        // No free granule: drop the sample, pointers stay put.
        w_ovf_set = 1'b1;
      end else if (!Channel_I) begin
        w_wr_l = 1'b1;
        wsl_d  = wsl_q + 5'd1;
        if (!Stereo_I) begin
          // Mono: the left sample is duplicated into the right RAM.
          w_wr_r   = 1'b1;
          w_addr_r = {wg_q, wsl_q};
          w_commit = (wsl_q == C_LAST_IDX);
        end
      end else if (Stereo_I) begin
        w_wr_r   = 1'b1;
        wsr_d    = wsr_q + 5'd1;
        w_commit = (wsr_q == C_LAST_IDX);
      end
    end
    if (w_commit) begin
      wg_d  = wg_q + LOG2_BLOCKS'(1);
      wsl_d = 5'd0;
      wsr_d = 5'd0;
    end
  end

  // Read FSM next state plus output-register and read-pointer updates.
  always_comb begin
    state_d   = state_q;
    rg_d      = rg_q;
    rs_d      = rs_q;
    valid_d   = valid_q;
    left_d    = left_q;
    right_d   = right_q;
    w_release = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (primed_q && (count_q != '0) && !valid_q) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        left_d  = rd_l_q;
        right_d = rd_r_q;
        valid_d = 1'b1;
        rs_d    = rs_q + 5'd1;
        if (rs_q == C_LAST_IDX) begin
          rg_d      = rg_q + LOG2_BLOCKS'(1);
          w_release = 1'b1;
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (Pair_Ready_I) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Granule count, prime latch and sticky flags (a set event beats a clear).
  always_comb begin
    case ({w_commit, w_release})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    primed_d  = primed_q | (count_q >= C_PRIME);
    w_unf_set = Pair_Ready_I && !valid_q && primed_q &&
                (count_q == '0) && (state_q == S_IDLE);
    ovf_d = ovf_q;
    if (Clear_Flags_I) ovf_d = 1'b0;
    if (w_ovf_set)     ovf_d = 1'b1;
    unf_d = unf_q;
    if (Clear_Flags_I) unf_d = 1'b0;
    if (w_unf_set)     unf_d = 1'b1;
  end

  // Read FSM state register; flush returns it to IDLE.
  always_ff @(posedge clock) begin
    if (reset || Flush_I) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers, count, prime, output pair and flags.
  always_ff @(posedge clock) begin
    if (reset || Flush_I) begin
      wg_q     <= '0;
      wsl_q    <= '0;
      wsr_q    <= '0;
      rg_q     <= '0;
      rs_q     <= '0;
      count_q  <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wg_q     <= wg_d;
      wsl_q    <= wsl_d;
      wsr_q    <= wsr_d;
      rg_q     <= rg_d;
      rs_q     <= rs_d;
      count_q  <= count_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      left_q   <= left_d;
      right_q  <= right_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Sample RAM write ports; contents survive flush and reset.
  always_ff @(posedge clock) begin
    if (w_wr_l) ram_l_q[w_addr_l] <= Sample_Data_I;
    if (w_wr_r) ram_r_q[w_addr_r] <= Sample_Data_I;
  end

  // Synchronous read port, addressed during FETCH and consumed in LOAD.
  always_ff @(posedge clock) begin
    if (state_q == S_FETCH) begin
      rd_l_q <= ram_l_q[w_rd_addr];
      rd_r_q <= ram_r_q[w_rd_addr];
    end
  end

endmodule
`default_nettype wire
